// File: rtl/serial_subtractor_if.sv
// serial_subtractor_if: handshake and operand/result bundle for serial_subtractor.
//
// Signals:
//   start       master -> slave  request a new operation; a and b sampled on the same edge
//   a           master -> slave  minuend, WIDTH bits
//   b           master -> slave  subtrahend, WIDTH bits
//   busy        slave -> master  high while bits are being shifted
//   done        slave -> master  one-cycle pulse when diff/borrow_out are updated
//   diff        slave -> master  registered result a - b mod 2^WIDTH
//   borrow_out  slave -> master  registered final borrow (a < b unsigned)
//   ovf         slave -> master  signed overflow, present only with SERIAL_SUB_OVF_EN
//
// Optional feature macro: SERIAL_SUB_OVF_EN.

interface serial_subtractor_if #(
  parameter int unsigned WIDTH = 8
) ();

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             borrow_out;
`ifdef SERIAL_SUB_OVF_EN
  logic             ovf;

  modport master (
    output start, a, b,
    input  busy, done, diff, borrow_out, ovf
  );

  modport slave (
    input  start, a, b,
    output busy, done, diff, borrow_out, ovf
  );
`else
  modport master (
    output start, a, b,
    input  busy, done, diff, borrow_out
  );

  modport slave (
    input  start, a, b,
    output busy, done, diff, borrow_out
  );
`endif

endinterface

// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial WIDTH-bit subtractor, diff = a - b, LSB first, one bit per clock.
// A single full-subtractor cell and a borrow flop are sequenced by a three-state FSM
// (idle / shift / done) with a start/busy/done handshake.
//
// Ports:
//   clk  input   rising-edge clock
//   rst  input   synchronous reset, active-high
//   bus  slave   serial_subtractor_if: start, a, b in; busy, done, diff, borrow_out (, ovf) out
//
// Timing: start sampled at edge k -> done high in the cycle after edge k+WIDTH.
// diff/borrow_out (and ovf) only change on entry to the done state or on reset.
//
// Optional feature macro: SERIAL_SUB_OVF_EN adds the registered two's-complement
// overflow flag bus.ovf, computed from the operand MSBs captured at start.

module serial_subtractor #(
  parameter int unsigned WIDTH = 8
) (
  input logic                clk,
  input logic                rst,
  serial_subtractor_if.slave bus
);

  // Counter only has to reach WIDTH-1.
  localparam int unsigned    CntW    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StDone
  } state_e;

  state_e           r_state;
  logic [WIDTH-1:0] r_a_sh;
  logic [WIDTH-1:0] r_b_sh;
  logic [WIDTH-1:0] r_res;
  logic [CntW-1:0]  r_cnt;
  logic             r_borrow;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_diff;
  logic             r_borrow_out;
`ifdef SERIAL_SUB_OVF_EN
  logic             r_a_msb;
  logic             r_b_msb;
  logic             r_ovf;
`endif

  // Full-subtractor cell on the current LSBs.
  logic             w_d;
  logic             w_borrow_nxt;
  logic [WIDTH-1:0] w_res_nxt;

  assign w_d          = r_a_sh[0] ^ r_b_sh[0] ^ r_borrow;
  assign w_borrow_nxt = (~r_a_sh[0] & r_b_sh[0]) | (~(r_a_sh[0] ^ r_b_sh[0]) & r_borrow);
  // New bit enters at the MSB; after WIDTH shifts the first (LSB) bit lands in bit 0.
  assign w_res_nxt    = {w_d, r_res[WIDTH-1:1]};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= StIdle;
      r_a_sh       <= '0;
      r_b_sh       <= '0;
      r_res        <= '0;
      r_cnt        <= '0;
      r_borrow     <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_diff       <= '0;
      r_borrow_out <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      r_a_msb      <= 1'b0;
      r_b_msb      <= 1'b0;
      r_ovf        <= 1'b0;
`endif
    end else begin
      // done is a single-cycle pulse; only the final shift edge raises it.
      r_done <= 1'b0;

      unique case (r_state)
        // The done state accepts start exactly like idle, allowing back-to-back operation.
        StIdle, StDone: begin
          if (bus.start) begin
            r_a_sh   <= bus.a;
            r_b_sh   <= bus.b;
            r_res    <= '0;
            r_borrow <= 1'b0;
            r_cnt    <= '0;
            r_busy   <= 1'b1;
`ifdef SERIAL_SUB_OVF_EN
            r_a_msb  <= bus.a[WIDTH-1];
            r_b_msb  <= bus.b[WIDTH-1];
`endif
            r_state  <= StShift;
          end else begin
            r_state  <= StIdle;
          end
        end

        // start is ignored here; the operands were captured on entry.
        StShift: begin
          r_a_sh   <= r_a_sh >> 1;
          r_b_sh   <= r_b_sh >> 1;
          r_res    <= w_res_nxt;
          r_borrow <= w_borrow_nxt;
          if (r_cnt == CntLast) begin
            // Clear rather than increment so the counter never wraps.
            r_cnt        <= '0;
            r_diff       <= w_res_nxt;
            r_borrow_out <= w_borrow_nxt;
`ifdef SERIAL_SUB_OVF_EN
            // w_d is the result MSB on this edge.
            r_ovf        <= (r_a_msb ^ r_b_msb) & (r_a_msb ^ w_d);
`endif
            r_busy       <= 1'b0;
            r_done       <= 1'b1;
            r_state      <= StDone;
          end else begin
            r_cnt        <= r_cnt + 1'b1;
          end
        end

        default: begin
          r_busy  <= 1'b0;
          r_state <= StIdle;
        end
      endcase
    end
  end

  assign bus.busy       = r_busy;
  assign bus.done       = r_done;
  assign bus.diff       = r_diff;
  assign bus.borrow_out = r_borrow_out;
`ifdef SERIAL_SUB_OVF_EN
  assign bus.ovf        = r_ovf;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: directed and random checks of serial_subtractor (WIDTH = 8) against
// an arithmetic reference model. Define SERIAL_SUB_OVF_EN to also check the overflow flag.

module tb_serial_subtractor;

  localparam int unsigned W = 8;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  serial_subtractor_if #(.WIDTH(W)) bus ();

  serial_subtractor #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference model: plain modular and signed arithmetic.
  function automatic logic [31:0] m_diff(input longint a, input longint b);
    longint m;
    m = longint'(1) << W;
    return 32'((a - b + m) % m);
  endfunction

  function automatic logic [31:0] m_borrow(input longint a, input longint b);
    return (a < b) ? 32'd1 : 32'd0;
  endfunction

  function automatic logic [31:0] m_ovf(input longint a, input longint b);
    longint sa;
    longint sb;
    longint r;
    sa = (a >= (longint'(1) << (W - 1))) ? a - (longint'(1) << W) : a;
    sb = (b >= (longint'(1) << (W - 1))) ? b - (longint'(1) << W) : b;
    r  = sa - sb;
    return ((r > (longint'(1) << (W - 1)) - 1) || (r < -(longint'(1) << (W - 1)))) ? 32'd1 : 32'd0;
  endfunction

  // One operation from idle; poke >= 0 re-asserts start (with zero operands) that many
  // cycles into the shift phase, which must be ignored.
  task automatic run_op(input string tag, input longint a, input longint b, input int poke);
    int lat;
    int busy_cycles;
    logic [31:0] exp_diff;
    exp_diff = m_diff(a, b);
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = W'(a);
    bus.b     = W'(b);
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.a     = W'($urandom);
    bus.b     = W'($urandom);
    lat         = 0;
    busy_cycles = 0;
    while (!bus.done && lat < 4 * W) begin
      if (bus.busy) busy_cycles++;
      if (lat == poke) begin
        bus.start = 1'b1;
        bus.a     = '0;
        bus.b     = '0;
      end else begin
        bus.start = 1'b0;
      end
      @(posedge clk);
      #1;
      lat++;
    end
    bus.start = 1'b0;
    // done becomes visible right after edge k+W.
    check({tag, "_latency"}, 32'(lat), 32'(W));
    check({tag, "_busy_cycles"}, 32'(busy_cycles), 32'(W));
    check({tag, "_busy_done"}, {30'd0, bus.busy, bus.done}, 32'd1);
    check({tag, "_diff"}, 32'(bus.diff), exp_diff);
    check({tag, "_borrow"}, 32'(bus.borrow_out), m_borrow(a, b));
`ifdef SERIAL_SUB_OVF_EN
    check({tag, "_ovf"}, 32'(bus.ovf), m_ovf(a, b));
`endif
    @(posedge clk);
    #1;
    check({tag, "_done_pulse"}, {30'd0, bus.busy, bus.done}, 32'd0);
    check({tag, "_diff_hold"}, 32'(bus.diff), exp_diff);
  endtask

  int          seen;
  int          n_done;
  int          last_done;
  logic        prev_done;
  longint      ra;
  longint      rb;

  initial begin
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_busy", 32'(bus.busy), 32'd0);
    check("reset_done", 32'(bus.done), 32'd0);
    check("reset_diff", 32'(bus.diff), 32'd0);
    check("reset_borrow", 32'(bus.borrow_out), 32'd0);
`ifdef SERIAL_SUB_OVF_EN
    check("reset_ovf", 32'(bus.ovf), 32'd0);
`endif
    rst = 1'b0;

    run_op("basic", 100, 37, -1);
    run_op("underflow", 5, 10, -1);
    run_op("zero", 0, 0, -1);

    // Start while busy: the second request must not launch an operation.
    run_op("start_busy", 200, 1, 3);
    seen = 0;
    repeat (2 * W) begin
      @(posedge clk);
      #1;
      if (bus.busy || bus.done) seen++;
    end
    check("start_busy_no_second_op", 32'(seen), 32'd0);

    // Back-to-back: start held high.
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = 8'hFF;
    bus.b     = 8'h01;
    n_done    = 0;
    last_done = -1;
    prev_done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (bus.done) begin
        n_done++;
        check("b2b_diff", 32'(bus.diff), 32'hFE);
        check("b2b_no_double_done", 32'(prev_done), 32'd0);
        if (last_done >= 0) check("b2b_spacing", 32'(i - last_done), 32'(W + 1));
        last_done = i;
      end
      prev_done = bus.done;
    end
    bus.start = 1'b0;
    check("b2b_count", 32'(n_done), 32'd4);
    repeat (2 * W) @(posedge clk);
    #1;

    // Reset in the 4th shift cycle.
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = 8'd50;
    bus.b     = 8'd20;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("midrst_busy", 32'(bus.busy), 32'd0);
    check("midrst_done", 32'(bus.done), 32'd0);
    check("midrst_diff", 32'(bus.diff), 32'd0);
    check("midrst_borrow", 32'(bus.borrow_out), 32'd0);
    seen = 0;
    repeat (2 * W) begin
      @(posedge clk);
      #1;
      if (bus.busy || bus.done) seen++;
    end
    check("midrst_no_done", 32'(seen), 32'd0);
    run_op("midrst_fresh", 50, 20, -1);

    // Signed overflow cases (diff/borrow checked in every build).
    run_op("ovf_set", 8'h80, 8'h01, -1);
    run_op("ovf_clear", 8'h10, 8'h01, -1);

    for (int i = 0; i < 20; i++) begin
      ra = longint'($urandom_range(0, (1 << W) - 1));
      rb = longint'($urandom_range(0, (1 << W) - 1));
      run_op("random", ra, rb, (i % 3 == 0) ? int'($urandom_range(0, W - 2)) : -1);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout observed=running expected=finished");
    $fatal(1, "watchdog");
  end

endmodule
